vga_scanout: RTL
================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter: BITS_PER_COLOUR_CHANNEL, default 1, meaning bits per colour in each framebuffer word; only 1 is supported, and rd_data width is 3*BITS_PER_COLOUR_CHANNEL.
REQ-002 Port: clock, input, 1, 50 MHz system clock; the block SHALL use this single clock.
REQ-003 Port: resetn, input, 1, reset, asynchronous and active-low.
REQ-004 Port: rd_addr, output, 15, framebuffer read address.
REQ-005 Port: rd_data, input, 3, framebuffer word {R,G,B}, valid one clock after rd_addr.
REQ-006 Port: VGA_R/VGA_G/VGA_B, output, 8 each, DAC colour.
REQ-007 Port: VGA_HS and VGA_VS, output, 1 each, syncs, active-low.
REQ-008 Port: VGA_BLANK_N, output, 1, high only in the visible region.
REQ-009 Port: VGA_SYNC_N, output, 1, held at 1.
REQ-010 Port: VGA_CLK, output, 1, 25 MHz DAC pixel clock.

Function
REQ-011 A divider flop SHALL toggle every clock; pix_en = (divider==1); VGA_CLK SHALL equal the divider flop.
REQ-012 h_cnt SHALL count 0..799 and v_cnt 0..524, both advancing on pix_en only.
- h_cnt wraps 799->0 and increments v_cnt.
- v_cnt wraps 524->0 when h_cnt wraps.
REQ-013 Visible region: h_cnt<640 and v_cnt<480. HS low for h_cnt 656..751. VS low for v_cnt 490..491.
REQ-014 Framebuffer coordinates: fx=h_cnt[9:2] (0..159), fy=v_cnt[8:2] (0..119); each stored pixel is replicated 4x4.
REQ-015 rd_addr SHALL be registered as fy*160+fx, computed as (fy<<7)+(fy<<5)+fx with no multiplier; range 0..19199.
REQ-016 Outside the visible region, rd_addr SHALL hold its last visible value.
REQ-017 Colour expansion: each rd_data bit SHALL be replicated to 8 bits (R=bit2, G=bit1, B=bit0).
REQ-018 RGB SHALL be forced to 0 whenever the delayed visible flag is 0.
REQ-019 RGB, HS, VS and BLANK_N SHALL all be delayed by exactly 2 pixel periods (4 clocks) from their counter values, so they stay mutually aligned.
REQ-020 Outputs SHALL change only on clocks where pix_en=1, which lands on the VGA_CLK falling edge.
REQ-021 One frame SHALL be 840000 clocks, with no gaps or stalls; rd_data SHALL be consumed unconditionally.

Reset
REQ-022 While resetn=0, the following SHALL hold:
- divider, h_cnt, v_cnt, rd_addr and all pipeline stages = 0.
- RGB = 0; VGA_BLANK_N = 0; VGA_HS = VGA_VS = 1.
REQ-023 Reset asserted mid-frame SHALL return the block to these values immediately.
REQ-024 After reset is released, the first frame SHALL begin at h_cnt=0, v_cnt=0.

Configuration
REQ-025 Macro VGA_SCANOUT_GRID_EN, when defined: visible pixels with (fx%10==0 or fy%10==0) and rd_data==3'b000 SHALL output colour 3'b001 (blue grid matching the 10x10 snake cell).
REQ-026 With VGA_SCANOUT_GRID_EN undefined, rd_data SHALL pass through unmodified and no modulo logic SHALL exist.
REQ-027 The modulo-10 tracking SHALL use counters reset at line/frame start, not dividers.

Structure
REQ-028 Package vga_pkg SHALL hold:
- timing constants H_VIS/H_FP/H_SYNC/H_BP/H_TOT and the V equivalents.
- FB_W=160, FB_H=120, FB_ADDR_W=15.
- GRID_CELL=10.
REQ-029 Sub-module vga_timing SHALL contain the divider, counters, sync and visible generation; vga_scanout SHALL add the address, colour pipeline and grid.

Verification
REQ-030 Release reset, run 2 frames: HS period = 1600 clocks, HS low for 192 clocks; VS period = 840000 clocks, VS low for 3200 clocks.
REQ-031 Memory model where word = addr[2:0]: at h_cnt=4,v_cnt=0 rd_addr=1; at v_cnt=8,h_cnt=0 rd_addr=320; the last visible pixel gives rd_addr=19199; RGB matches the word 4 clocks after the counters.
REQ-032 All-white memory (3'b111): RGB = 0xFF during BLANK_N=1 and 0 during blanking; BLANK_N high for 1280 clocks per line.
REQ-033 Assert resetn low at v_cnt=300 for 3 clocks: outputs take reset values asynchronously; after release the next VS falling edge occurs 490*1600 + 4 clocks later.
REQ-034 With GRID_EN and an all-zero memory: fx=0,10,20 and fy=0 output B=0xFF; fx=5,fy=5 outputs black; a nonzero word at fx=10 passes through unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, framebuffer geometry and helpers
// for the vga_scanout block.
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;
    localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_CNT_W = 10;
    localparam int unsigned V_CNT_W = 10;

    // Framebuffer: 160x120, each stored pixel covers a 4x4 screen block
    localparam int unsigned FB_W      = 160;
    localparam int unsigned FB_H      = 120;
    localparam int unsigned FB_ADDR_W = $clog2(FB_W * FB_H);
    localparam int unsigned FX_W      = 8;
    localparam int unsigned FY_W      = 7;

    // Grid overlay cell size in framebuffer pixels
    localparam int unsigned GRID_CELL = 10;
    localparam int unsigned GRID_W    = 4;

    localparam int unsigned DAC_W = 8;

    // Control bits that travel down the pipeline next to the pixel data
    typedef struct packed {
        logic visible;
        logic hpulse;
        logic vpulse;
    } vga_ctrl_t;

    // fy*160 + fx built from two shifts and adds
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FY_W-1:0] fy,
                                                     input logic [FX_W-1:0] fx);
        return FB_ADDR_W'({fy, 7'b0}) + FB_ADDR_W'({fy, 5'b0}) + FB_ADDR_W'(fx);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider, h/v counters and raw sync/visible decode.
// With VGA_SCANOUT_GRID_EN defined, also exports the step strobes used by
// the grid overlay's modulo counters.
module vga_timing
    import vga_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            div_o,
    output logic            pix_en_c_o,
    output logic [FX_W-1:0] fx_o,
    output logic [FY_W-1:0] fy_o,
`ifdef VGA_SCANOUT_GRID_EN
    output logic            line_end_c_o,
    output logic            frame_end_c_o,
    output logic            fx_step_c_o,
    output logic            fy_step_c_o,
`endif
    output logic            visible_c_o,
    output logic            hpulse_c_o,
    output logic            vpulse_c_o
);

    logic               div_q, div_d;
    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic               line_end_c;
    logic               frame_end_c;

    // A pixel slot ends on the clock where the divider is high
    assign line_end_c  = div_q && (h_cnt_q == H_CNT_W'(H_TOT - 1));
    assign frame_end_c = line_end_c && (v_cnt_q == V_CNT_W'(V_TOT - 1));

    // Next-state for divider and raster counters
    always_comb begin
        div_d   = ~div_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (line_end_c) begin
            h_cnt_d = '0;
            v_cnt_d = frame_end_c ? '0 : v_cnt_q + V_CNT_W'(1);
        end else if (div_q) begin
            h_cnt_d = h_cnt_q + H_CNT_W'(1);
        end
    end

    // Divider and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign div_o       = div_q;
    assign pix_en_c_o  = div_q;
    assign fx_o        = h_cnt_q[H_CNT_W-1:2];
    assign fy_o        = v_cnt_q[FY_W+1:2];
    assign visible_c_o = (h_cnt_q < H_CNT_W'(H_VIS)) && (v_cnt_q < V_CNT_W'(V_VIS));
    assign hpulse_c_o  = (h_cnt_q >= H_CNT_W'(H_VIS + H_FP))
                      && (h_cnt_q <  H_CNT_W'(H_VIS + H_FP + H_SYNC));
    assign vpulse_c_o  = (v_cnt_q >= V_CNT_W'(V_VIS + V_FP))
                      && (v_cnt_q <  V_CNT_W'(V_VIS + V_FP + V_SYNC));

`ifdef VGA_SCANOUT_GRID_EN
    assign line_end_c_o  = line_end_c;
    assign frame_end_c_o = frame_end_c;
    assign fx_step_c_o   = div_q && (h_cnt_q[1:0] == 2'b11);
    assign fy_step_c_o   = line_end_c && (v_cnt_q[1:0] == 2'b11);
`endif

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: reads a 160x120 3-bit framebuffer and drives the DAC with
// 4x4 pixel replication. Sync, blank and colour leave two pixel slots after
// the counters so they stay aligned. Optional blue 10x10 grid overlay on
// black pixels is enabled by defining VGA_SCANOUT_GRID_EN.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned BITS_PER_COLOUR_CHANNEL = 1
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    output logic [FB_ADDR_W-1:0]                 rd_addr,
    input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0] rd_data,
    output logic [DAC_W-1:0]                     VGA_R,
    output logic [DAC_W-1:0]                     VGA_G,
    output logic [DAC_W-1:0]                     VGA_B,
    output logic                                 VGA_HS,
    output logic                                 VGA_VS,
    output logic                                 VGA_BLANK_N,
    output logic                                 VGA_SYNC_N,
    output logic                                 VGA_CLK
);

    localparam int unsigned BPC   = BITS_PER_COLOUR_CHANNEL;
    localparam int unsigned RGB_W = 3 * BPC;

    logic            div;
    logic            pix_en_c;
    logic [FX_W-1:0] fx;
    logic [FY_W-1:0] fy;
    logic            visible_c;
    logic            hpulse_c;
    logic            vpulse_c;

    logic [FB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    vga_ctrl_t            ctrl_q, ctrl_d;
    logic [RGB_W-1:0]     col_c;
    logic [DAC_W-1:0]     r_q, r_d, g_q, g_d, b_q, b_d;
    logic                 hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

`ifdef VGA_SCANOUT_GRID_EN
    logic              line_end_c, frame_end_c, fx_step_c, fy_step_c;
    logic [GRID_W-1:0] fx_mod_q, fx_mod_d, fy_mod_q, fy_mod_d;
    logic              grid_q, grid_d;
`endif

    vga_timing u_timing (
        .clk_i         (clock),
        .rst_ni        (resetn),
        .div_o         (div),
        .pix_en_c_o    (pix_en_c),
        .fx_o          (fx),
        .fy_o          (fy),
`ifdef VGA_SCANOUT_GRID_EN
        .line_end_c_o  (line_end_c),
        .frame_end_c_o (frame_end_c),
        .fx_step_c_o   (fx_step_c),
        .fy_step_c_o   (fy_step_c),
`endif
        .visible_c_o   (visible_c),
        .hpulse_c_o    (hpulse_c),
        .vpulse_c_o    (vpulse_c)
    );

    // Stage 1: issue the framebuffer read and capture the matching controls
    always_comb begin
        rd_addr_d = rd_addr_q;
        ctrl_d    = ctrl_q;
        if (pix_en_c) begin
            ctrl_d.visible = visible_c;
            ctrl_d.hpulse  = hpulse_c;
            ctrl_d.vpulse  = vpulse_c;
            if (visible_c) begin
                rd_addr_d = fb_addr(fy, fx);
            end
        end
    end

`ifdef VGA_SCANOUT_GRID_EN
    // Modulo-10 trackers of fx/fy, cleared at line and frame start
    always_comb begin
        fx_mod_d = fx_mod_q;
        fy_mod_d = fy_mod_q;
        grid_d   = grid_q;
        if (line_end_c) begin
            fx_mod_d = '0;
        end else if (fx_step_c) begin
            fx_mod_d = (fx_mod_q == GRID_W'(GRID_CELL - 1)) ? '0 : fx_mod_q + GRID_W'(1);
        end
        if (frame_end_c) begin
            fy_mod_d = '0;
        end else if (fy_step_c) begin
            fy_mod_d = (fy_mod_q == GRID_W'(GRID_CELL - 1)) ? '0 : fy_mod_q + GRID_W'(1);
        end
        if (pix_en_c) begin
            grid_d = (fx_mod_q == '0) || (fy_mod_q == '0);
        end
    end

    // Grid tracker registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fx_mod_q <= '0;
            fy_mod_q <= '0;
            grid_q   <= 1'b0;
        end else begin
            fx_mod_q <= fx_mod_d;
            fy_mod_q <= fy_mod_d;
            grid_q   <= grid_d;
        end
    end
`endif

    // Colour word selection; black grid cells become blue when enabled
    always_comb begin
        col_c = rd_data;
`ifdef VGA_SCANOUT_GRID_EN
        if (grid_q && (rd_data == '0)) begin
            col_c = RGB_W'(1);
        end
`endif
    end

    // Stage 2: expand colour and register all DAC-side outputs together
    always_comb begin
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        if (pix_en_c) begin
            blank_n_d = ctrl_q.visible;
            hs_d      = ~ctrl_q.hpulse;
            vs_d      = ~ctrl_q.vpulse;
            r_d       = ctrl_q.visible ? {DAC_W{col_c[3*BPC-1]}} : '0;
            g_d       = ctrl_q.visible ? {DAC_W{col_c[2*BPC-1]}} : '0;
            b_d       = ctrl_q.visible ? {DAC_W{col_c[BPC-1]}}   : '0;
        end
    end

    // Pipeline registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_addr_q <= '0;
            ctrl_q    <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            ctrl_q    <= ctrl_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_CLK     = div;

endmodule
